// File: rtl/game_ctrl_if.sv
// Player move request channel: valid/ready handshake carrying a 2-bit move code.
interface game_ctrl_if;
    logic       btn_valid;
    logic [1:0] btn_move;
    logic       btn_ready;

    modport master (output btn_valid, output btn_move, input btn_ready);
    modport slave  (input btn_valid, input btn_move, output btn_ready);
endinterface

// File: rtl/game_ctrl.sv
// Game sequencer: owns board/piece/location/rotation registers, issues player and gravity
// moves to the datapath, and counts cleared lines.
module game_ctrl #(
    parameter int TICK_DIV = 16,
    parameter int LINES_W  = 8
) (
    input  logic               clka,
    input  logic               restart,
    game_ctrl_if.slave         btn,
    output logic [2:0]         state,
    output logic [1:0]         move,
    output logic [31:0]        board_q,
    output logic [1:0]         piece_q,
    output logic [4:0]         location_q,
    output logic [1:0]         rotation_q,
    input  logic [1:0]         dp_piece,
    input  logic [4:0]         dp_location,
    input  logic [1:0]         dp_rotation,
    input  logic [31:0]        dp_board,
    input  logic               dp_touched,
    output logic [LINES_W-1:0] lines,
    output logic               game_over
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam int LS = LINES_W + 4;
    localparam logic [LS-1:0] LINES_MAX = {4'b0, {LINES_W{1'b1}}};

    typedef enum logic [2:0] {
        S_GEN      = 3'd0,
        S_MOVE     = 3'd1,
        S_LAND     = 3'd2,
        S_CLEAR    = 3'd3,
        S_NEWBOARD = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    typedef enum logic {PH_ISSUE = 1'b0, PH_WAIT = 1'b1} phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic               grav_q, grav_d;
    logic [1:0]         mv_q, mv_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [31:0]        board_d;
    logic [1:0]         piece_d;
    logic [4:0]         loc_d;
    logic [1:0]         rot_d;
    logic [LINES_W-1:0] lines_q, lines_d;
    logic               go_q, go_d;

    logic [7:0]    row_full;
    logic [3:0]    full_cnt;
    logic [LS-1:0] lines_sum;

    genvar r;
    generate
        for (r = 0; r < 8; r++) begin : g_row
            assign row_full[r] = &board_q[4*r +: 4];
        end
    endgenerate

    always_comb begin
        full_cnt = '0;
        for (int i = 0; i < 8; i++)
            full_cnt = full_cnt + {3'b0, row_full[i]};
    end

    assign lines_sum = LS'(lines_q) + LS'(full_cnt);

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        grav_d        = grav_q;
        mv_d          = mv_q;
        tick_d        = tick_q;
        board_d       = board_q;
        piece_d       = piece_q;
        loc_d         = location_q;
        rot_d         = rotation_q;
        lines_d       = lines_q;
        btn.btn_ready = 1'b0;
        move          = 2'd3;

        case (state_q)
            S_NEWBOARD: begin
                board_d = '0;
                state_d = S_GEN;
            end
            S_GEN: begin
                piece_d = dp_piece;
                loc_d   = (dp_piece < 2'd2) ? 5'd1 : 5'd5;
                rot_d   = '0;
                tick_d  = '0;
                phase_d = PH_ISSUE;
                state_d = (board_q[3:0] != 4'h0) ? S_GAMEOVER : S_MOVE;
            end
            S_MOVE: begin
                if (phase_q == PH_ISSUE) begin
                    // Gravity wins the slot; a pending button simply waits for the next ISSUE.
                    if (tick_q == TICK_MAX) begin
                        tick_d  = '0;
                        mv_d    = 2'd3;
                        grav_d  = 1'b1;
                        phase_d = PH_WAIT;
                    end else begin
                        btn.btn_ready = 1'b1;
                        tick_d        = tick_q + 1'b1;
                        if (btn.btn_valid) begin
                            move    = btn.btn_move;
                            mv_d    = btn.btn_move;
                            grav_d  = 1'b0;
                            phase_d = PH_WAIT;
                        end
                    end
                end else begin
                    move    = mv_q;
                    loc_d   = dp_location;
                    rot_d   = dp_rotation;
                    // Hold at the terminal count so gravity fires on the first ISSUE after WAIT.
                    tick_d  = (tick_q == TICK_MAX) ? tick_q : tick_q + 1'b1;
                    phase_d = PH_ISSUE;
                    if (grav_q && dp_touched)
                        state_d = S_LAND;
                end
            end
            S_LAND: begin
                board_d = dp_board;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                lines_d = (lines_sum > LINES_MAX) ? {LINES_W{1'b1}} : lines_sum[LINES_W-1:0];
                board_d = dp_board;
                state_d = S_GEN;
            end
            S_GAMEOVER: begin
                state_d = S_GAMEOVER;
            end
            default: begin
                state_d = S_NEWBOARD;
            end
        endcase

        go_d = (state_d == S_GAMEOVER);
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q    <= S_NEWBOARD;
            phase_q    <= PH_ISSUE;
            grav_q     <= 1'b0;
            mv_q       <= 2'd3;
            tick_q     <= '0;
            board_q    <= '0;
            piece_q    <= '0;
            location_q <= '0;
            rotation_q <= '0;
            lines_q    <= '0;
            go_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            grav_q     <= grav_d;
            mv_q       <= mv_d;
            tick_q     <= tick_d;
            board_q    <= board_d;
            piece_q    <= piece_d;
            location_q <= loc_d;
            rotation_q <= rot_d;
            lines_q    <= lines_d;
            go_q       <= go_d;
        end
    end

    assign state     = state_q;
    assign lines     = lines_q;
    assign game_over = go_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus queues expected state-entry snapshots and
// handshake results; a negedge monitor pops and compares them as the DUT produces them.
module tb_game_ctrl;
    localparam int TD = 8;

    logic        clka, restart;
    logic [2:0]  state;
    logic [1:0]  move, piece_q, rotation_q, dp_piece, dp_rotation;
    logic [31:0] board_q, dp_board, land_b, clear_b;
    logic [4:0]  location_q, dp_location;
    logic        dp_touched, game_over;
    logic [7:0]  lines;

    game_ctrl_if bif ();

    game_ctrl #(.TICK_DIV(TD), .LINES_W(8)) dut (
        .clka(clka), .restart(restart), .btn(bif.slave),
        .state(state), .move(move), .board_q(board_q), .piece_q(piece_q),
        .location_q(location_q), .rotation_q(rotation_q),
        .dp_piece(dp_piece), .dp_location(dp_location), .dp_rotation(dp_rotation),
        .dp_board(dp_board), .dp_touched(dp_touched),
        .lines(lines), .game_over(game_over)
    );

    // Datapath stand-in: merged board while landing, collapsed board while clearing.
    assign dp_board = (state == 3'd3) ? clear_b : land_b;

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] board;
        logic [7:0]  lines;
        logic [1:0]  piece;
        logic [4:0]  loc;
        logic [1:0]  rot;
        logic        go;
    } snap_t;

    typedef struct packed {
        logic [1:0] mv;
        logic [4:0] loc;
    } hs_t;

    snap_t snap_q[$];
    hs_t   hs_q[$];
    int    n_cmp = 0, n_err = 0;
    logic  mon_en = 1'b0;

    logic [31:0] m_board;
    logic [7:0]  m_lines;
    logic [1:0]  m_piece, m_rot;
    logic [4:0]  m_loc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clka);
        #1;
    endtask

    task automatic wait_st(input logic [2:0] st, input int max_cyc);
        int n = 0;
        while (state !== st && n < max_cyc) begin
            step(1);
            n++;
        end
        if (state !== st) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_state: got state %0d expected %0d", state, st);
        end
    endtask

    task automatic push_snap(input logic [2:0] st, input logic go);
        snap_q.push_back({st, m_board, m_lines, m_piece, m_loc, m_rot, go});
    endtask

    task automatic zero_model();
        m_board = '0; m_lines = '0; m_piece = '0; m_loc = '0; m_rot = '0;
    endtask

    // One piece: fall to the floor by gravity, land, clear nfull rows, spawn next piece.
    task automatic piece(input logic [31:0] lb, input logic [31:0] cb, input int nfull,
                         input logic [4:0] loc, input logic [1:0] nxt);
        int s;
        land_b = lb; clear_b = cb; dp_location = loc; dp_piece = nxt; dp_touched = 1'b1;
        m_loc = loc; m_rot = 2'd1;
        push_snap(3'd2, 1'b0);
        m_board = lb;
        push_snap(3'd3, 1'b0);
        m_board = cb;
        s = int'(m_lines) + nfull;
        m_lines = (s > 255) ? 8'd255 : 8'(s);
        push_snap(3'd0, 1'b0);
        m_piece = nxt; m_loc = (nxt < 2'd2) ? 5'd1 : 5'd5; m_rot = 2'd0;
        if (cb[3:0] != 4'h0) push_snap(3'd5, 1'b1);
        else                 push_snap(3'd1, 1'b0);
        wait_st(3'd2, 30);
        dp_touched = 1'b0;
        wait_st((cb[3:0] != 4'h0) ? 3'd5 : 3'd1, 10);
    endtask

    // Monitor: checks each state entry against the next queued snapshot, and each accepted
    // button against the next queued handshake (move now, location two cycles later).
    initial begin
        logic [2:0] prev;
        int         hs_cnt;
        hs_t        hcur;
        snap_t      got, e;
        prev = '0; hs_cnt = 0; hcur = '0;
        forever begin
            @(negedge clka);
            if (hs_cnt > 0) begin
                hs_cnt--;
                if (hs_cnt == 0) chk("hs_location", 32'(location_q), 32'(hcur.loc));
            end
            if (mon_en) begin
                if (state !== prev) begin
                    got = {state, board_q, lines, piece_q, location_q, rotation_q, game_over};
                    n_cmp++;
                    if (snap_q.size() == 0) begin
                        n_err++;
                        $display("FAIL state_entry: got unexpected state %0d expected no change", state);
                    end else begin
                        e = snap_q.pop_front();
                        if (got !== e) begin
                            n_err++;
                            $display("FAIL state_entry: got %h expected %h (st,board,lines,piece,loc,rot,go)", got, e);
                        end
                    end
                end
                if (bif.btn_valid && bif.btn_ready) begin
                    if (hs_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL handshake: got unexpected accept of move %0d expected none", bif.btn_move);
                    end else begin
                        hcur = hs_q.pop_front();
                        chk("hs_move", 32'(move), 32'(hcur.mv));
                        hs_cnt = 2;
                    end
                end
            end
            prev = state;
        end
    end

    initial begin
        restart = 1'b1; bif.btn_valid = 1'b0; bif.btn_move = 2'd0;
        dp_piece = 2'd1; dp_location = 5'd0; dp_rotation = 2'd1; dp_touched = 1'b0;
        land_b = '0; clear_b = '0;
        zero_model();

        // T1: reset state, then NEWBOARD -> GEN -> MOVE
        step(2);
        chk("rst_state", 32'(state), 32'd4);
        chk("rst_board", board_q, 32'd0);
        chk("rst_lines", 32'(lines), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_btn_ready", 32'(bif.btn_ready), 32'd0);
        chk("rst_move", 32'(move), 32'd3);
        mon_en = 1'b1;
        push_snap(3'd0, 1'b0);
        m_piece = 2'd1; m_loc = 5'd1;
        push_snap(3'd1, 1'b0);
        restart = 1'b0;
        step(2);

        // T2: player move left, tick = 0
        bif.btn_valid = 1'b1; bif.btn_move = 2'd0; dp_location = 5'd4;
        hs_q.push_back({2'd0, 5'd4});
        chk("t2_ready_issue", 32'(bif.btn_ready), 32'd1);
        step(1);
        bif.btn_valid = 1'b0;
        chk("t2_move_wait", 32'(move), 32'd0);
        chk("t2_ready_wait", 32'(bif.btn_ready), 32'd0);
        step(1);
        chk("t2_location", 32'(location_q), 32'd4);
        chk("t2_rotation", 32'(rotation_q), 32'd1);
        chk("t2_ready_back", 32'(bif.btn_ready), 32'd1);

        // T3: button held across the gravity slot (tick now 2, gravity at tick 7)
        step(5);
        bif.btn_valid = 1'b1; bif.btn_move = 2'd1; dp_location = 5'd6;
        chk("t3_ready_grav", 32'(bif.btn_ready), 32'd0);
        chk("t3_move_grav", 32'(move), 32'd3);
        step(1);
        chk("t3_ready_wait", 32'(bif.btn_ready), 32'd0);
        chk("t3_move_wait", 32'(move), 32'd3);
        step(1);
        chk("t3_loc_grav", 32'(location_q), 32'd6);
        chk("t3_ready_after", 32'(bif.btn_ready), 32'd1);
        hs_q.push_back({2'd1, 5'd7});
        dp_location = 5'd7;
        step(1);
        bif.btn_valid = 1'b0;
        step(1);
        m_loc = 5'd7;

        // T4: landing with rows 7,6 full and a partial row 5
        piece(32'hFF30_0000, 32'h3000_0000, 2, 5'd8, 2'd2);
        chk("t4_lines", 32'(lines), 32'd2);
        chk("t4_board", board_q, 32'h3000_0000);

        // T5: fill to 254 then saturate at 255
        for (int i = 0; i < 31; i++)
            piece(32'hFFFF_FFFF, 32'h0, 8, 5'(i), 2'(i));
        piece(32'hFFFF_0000, 32'h0, 4, 5'd20, 2'd0);
        chk("t5_lines_254", 32'(lines), 32'd254);
        piece(32'hFFF7_0000, 32'h7000_0000, 3, 5'd21, 2'd1);
        chk("t5_lines_sat", 32'(lines), 32'd255);

        // T6: top row occupied at GEN -> GAMEOVER
        piece(32'h7000_0002, 32'h7000_0002, 0, 5'd9, 2'd3);
        bif.btn_valid = 1'b1; bif.btn_move = 2'd2;
        step(1);
        chk("t6_game_over", 32'(game_over), 32'd1);
        chk("t6_ready", 32'(bif.btn_ready), 32'd0);
        chk("t6_move", 32'(move), 32'd3);
        step(3);
        chk("t6_hold_state", 32'(state), 32'd5);
        chk("t6_hold_lines", 32'(lines), 32'd255);

        restart = 1'b1; bif.btn_valid = 1'b0;
        zero_model();
        push_snap(3'd4, 1'b0);
        push_snap(3'd0, 1'b0);
        m_piece = 2'd3; m_loc = 5'd5;
        push_snap(3'd1, 1'b0);
        step(1);
        restart = 1'b0;
        wait_st(3'd1, 5);

        // Restart during a player WAIT: location must not be latched
        bif.btn_valid = 1'b1; bif.btn_move = 2'd2; dp_location = 5'd13;
        hs_q.push_back({2'd2, 5'd0});
        zero_model();
        push_snap(3'd4, 1'b0);
        push_snap(3'd0, 1'b0);
        m_piece = 2'd3; m_loc = 5'd5;
        push_snap(3'd1, 1'b0);
        step(1);
        restart = 1'b1; bif.btn_valid = 1'b0;
        step(1);
        chk("t6_restart_state", 32'(state), 32'd4);
        chk("t6_restart_loc", 32'(location_q), 32'd0);
        restart = 1'b0;
        wait_st(3'd1, 5);
        step(2);

        chk("snap_queue_drained", 32'(snap_q.size()), 32'd0);
        chk("hs_queue_drained", 32'(hs_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
